// File: rtl/alarm_ringer.sv
// alarm_ringer: turns the comparator alarm level into a buzzer pattern and LED, with dismiss, snooze and timeout.
// Optional build macro ESCALATE_EN: after 10 s of ringing the tone goes continuous at double pitch.
module alarm_ringer #(
  parameter int TONE_DIV       = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       newclk,
  input  logic       rst_n,
  input  logic       alarm_do,
  input  logic       sec_tick,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       ringing,
  output logic       alarm_clear,
  output logic       snooze_retrig,
  output logic [8:0] snooze_left
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam int         HALF_NORM    = (TONE_DIV < 1) ? 1 : TONE_DIV;
  localparam logic [7:0] HALF_NORM_M1 = 8'(HALF_NORM - 1);
  localparam logic [6:0] RING_LOAD    = 7'(RING_TIMEOUT_S);
  localparam logic [8:0] SNZ_LOAD     = 9'(SNOOZE_S);

  state_t     state;
  logic       alarm_do_p0, dismiss_p0, snooze_p0;
  logic       do_rise, dis_rise, snz_rise;
  logic [6:0] ring_cnt;
  logic [1:0] snooze_cnt;
  logic [7:0] tone_cnt;
  logic [7:0] half_m1;
  logic       tone_q, beep_phase;
  logic       tone_wrap, tone_nxt, phase_nxt;
  logic       snooze_at_max, ring_stop;

  function automatic logic [6:0] sat_dec7(input logic [6:0] v);
    return (v == 7'd0) ? 7'd0 : v - 7'd1;
  endfunction

  function automatic logic [8:0] sat_dec9(input logic [8:0] v);
    return (v == 9'd0) ? 9'd0 : v - 9'd1;
  endfunction

  assign do_rise  = alarm_do & ~alarm_do_p0;
  assign dis_rise = dismiss & ~dismiss_p0;
  assign snz_rise = snooze & ~snooze_p0;

  assign snooze_at_max = (int'(snooze_cnt) >= MAX_SNOOZE);
  // dismiss beats snooze beats timeout; an exhausted snooze behaves as dismiss
  assign ring_stop = dis_rise | (snz_rise & snooze_at_max) |
                     (~snz_rise & sec_tick & (ring_cnt <= 7'd1));

`ifdef ESCALATE_EN
  localparam int         HALF_ESC    = (TONE_DIV / 2 < 1) ? 1 : TONE_DIV / 2;
  localparam logic [7:0] HALF_ESC_M1 = 8'(HALF_ESC - 1);
  logic [3:0] esc_cnt;
  logic       escalated, esc_hit;
  assign escalated = (esc_cnt == 4'd10);
  assign esc_hit   = escalated | (sec_tick & (esc_cnt == 4'd9));
  assign half_m1   = escalated ? HALF_ESC_M1 : HALF_NORM_M1;
  assign phase_nxt = esc_hit | (beep_phase ^ sec_tick);
`else
  assign half_m1   = HALF_NORM_M1;
  assign phase_nxt = beep_phase ^ sec_tick;
`endif

  // >= so a half-period shrink mid-count wraps at once instead of running to 255
  assign tone_wrap = (tone_cnt >= half_m1);
  assign tone_nxt  = tone_wrap ? ~tone_q : tone_q;

  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      alarm_do_p0   <= 1'b0;
      dismiss_p0    <= 1'b0;
      snooze_p0     <= 1'b0;
      ring_cnt      <= '0;
      snooze_left   <= '0;
      snooze_cnt    <= '0;
      tone_cnt      <= '0;
      tone_q        <= 1'b0;
      beep_phase    <= 1'b0;
      buzzer        <= 1'b0;
      alarm_led     <= 1'b0;
      ringing       <= 1'b0;
      alarm_clear   <= 1'b0;
      snooze_retrig <= 1'b0;
`ifdef ESCALATE_EN
      esc_cnt       <= '0;
`endif
    end else begin
      alarm_do_p0   <= alarm_do;
      dismiss_p0    <= dismiss;
      snooze_p0     <= snooze;
      alarm_clear   <= 1'b0;
      snooze_retrig <= 1'b0;
      case (state)
        IDLE: begin
          if (do_rise) begin
            state      <= RING;
            ringing    <= 1'b1;
            alarm_led  <= 1'b1;
            ring_cnt   <= RING_LOAD;
            snooze_cnt <= '0;
            tone_cnt   <= '0;
            tone_q     <= 1'b0;
            beep_phase <= 1'b1;
            buzzer     <= 1'b0;
`ifdef ESCALATE_EN
            esc_cnt    <= '0;
`endif
          end
        end
        RING: begin
          if (ring_stop) begin
            state       <= IDLE;
            alarm_clear <= 1'b1;
            ringing     <= 1'b0;
            alarm_led   <= 1'b0;
            buzzer      <= 1'b0;
            beep_phase  <= 1'b0;
            tone_cnt    <= '0;
            tone_q      <= 1'b0;
            snooze_cnt  <= '0;
            snooze_left <= '0;
          end else if (snz_rise) begin
            state       <= SNOOZE;
            alarm_clear <= 1'b1;
            ringing     <= 1'b0;
            alarm_led   <= SNZ_LOAD[0];
            buzzer      <= 1'b0;
            beep_phase  <= 1'b0;
            tone_cnt    <= '0;
            tone_q      <= 1'b0;
            snooze_left <= SNZ_LOAD;
            snooze_cnt  <= snooze_cnt + 2'd1;
          end else begin
            tone_cnt   <= tone_wrap ? 8'd0 : tone_cnt + 8'd1;
            tone_q     <= tone_nxt;
            beep_phase <= phase_nxt;
            buzzer     <= tone_nxt & phase_nxt;
            if (sec_tick) begin
              ring_cnt <= sat_dec7(ring_cnt);
`ifdef ESCALATE_EN
              if (esc_cnt != 4'd10) esc_cnt <= esc_cnt + 4'd1;
`endif
            end
          end
        end
        SNOOZE: begin
          if (dis_rise) begin
            state       <= IDLE;
            alarm_led   <= 1'b0;
            snooze_left <= '0;
            snooze_cnt  <= '0;
          end else if (sec_tick) begin
            if (snooze_left <= 9'd1) begin
              state         <= RING;
              snooze_retrig <= 1'b1;
              ringing       <= 1'b1;
              alarm_led     <= 1'b1;
              snooze_left   <= '0;
              ring_cnt      <= RING_LOAD;
              tone_cnt      <= '0;
              tone_q        <= 1'b0;
              beep_phase    <= 1'b1;
              buzzer        <= 1'b0;
`ifdef ESCALATE_EN
              esc_cnt       <= '0;
`endif
            end else begin
              snooze_left <= sat_dec9(snooze_left);
              // decrementing a value >= 2 always flips its LSB
              alarm_led   <= ~snooze_left[0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with SNOOZE_S shortened to 5 s; expected values are hand-derived.
module tb_alarm_ringer;

  logic       newclk, rst_n, alarm_do, sec_tick, dismiss, snooze;
  logic       buzzer, alarm_led, ringing, alarm_clear, snooze_retrig;
  logic [8:0] snooze_left;
  int         checks   = 0;
  int         failures = 0;

  alarm_ringer #(
    .TONE_DIV(4), .RING_TIMEOUT_S(60), .SNOOZE_S(5), .MAX_SNOOZE(3)
  ) dut (
    .newclk(newclk), .rst_n(rst_n), .alarm_do(alarm_do), .sec_tick(sec_tick),
    .dismiss(dismiss), .snooze(snooze), .buzzer(buzzer), .alarm_led(alarm_led),
    .ringing(ringing), .alarm_clear(alarm_clear), .snooze_retrig(snooze_retrig),
    .snooze_left(snooze_left)
  );

  initial begin
    newclk = 1'b0;
    forever #5 newclk = ~newclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // bit 13 buzzer, 12 alarm_led, 11 ringing, 10 alarm_clear, 9 snooze_retrig, 8:0 snooze_left
  function automatic logic [31:0] outs();
    return {18'b0, buzzer, alarm_led, ringing, alarm_clear, snooze_retrig, snooze_left};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge newclk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic press_dis();
    dismiss = 1'b1;
    cyc();
    dismiss = 1'b0;
  endtask

  task automatic press_snz();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
  endtask

  initial begin
    int exp_b;
    int toggles;
    logic prev_b;
    rst_n = 1'b0; alarm_do = 1'b0; sec_tick = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    cyc(); cyc();
    chk("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_outs", outs(), 32'd0);

    // ring, buzzer pattern over five 16-cycle seconds, then dismiss
    alarm_do = 1'b1;
    cyc();
    chk("ring_enter", 32'(ringing), 1);
    chk("ring_led", 32'(alarm_led), 1);
    chk("ring_buz0", 32'(buzzer), 0);
    for (int j = 1; j <= 80; j++) begin
      sec_tick = (j % 16 == 0);
      cyc();
      sec_tick = 1'b0;
      exp_b = ((j / 4) % 2 == 1 && (j / 16) % 2 == 0) ? 1 : 0;
      chk($sformatf("buzz_c%0d", j), 32'(buzzer), 32'(exp_b));
    end
    chk("ring_5s", 32'(ringing), 1);
    press_dis();
    chk("dis_outs", outs(), 32'h400);
    alarm_do = 1'b0;
    cyc();
    chk("dis_pulse_end", outs(), 32'd0);

    // async reset in the middle of ringing
    alarm_do = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      tick(); cyc();
    end
    chk("rstmid_ring", 32'(ringing), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_async", outs(), 32'd0);
    alarm_do = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rstmid_nopulse", outs(), 32'd0);

    // snooze countdown, retrigger and echoed alarm_do
    alarm_do = 1'b1;
    cyc();
    press_snz();
    chk("snz_outs", outs(), 32'h1405);
    alarm_do = 1'b0;
    cyc();
    chk("snz_pulse_end", outs(), 32'h1005);
    for (int s = 4; s >= 1; s--) begin
      tick();
      chk($sformatf("snz_left%0d", s), 32'(snooze_left), 32'(s));
      chk($sformatf("snz_led%0d", s), 32'(alarm_led), 32'(s % 2));
      cyc();
    end
    press_snz();
    chk("snz_ignored", outs(), 32'h1001);
    tick();
    chk("retrig_outs", outs(), 32'h1A00);
    alarm_do = 1'b1;
    cyc();
    chk("echo_ignored", outs(), 32'h1800);

    // three snoozes allowed, the fourth dismisses
    press_dis();
    chk("dis2", outs(), 32'h400);
    alarm_do = 1'b0;
    cyc();
    alarm_do = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      press_snz();
      chk($sformatf("snzk%0d_enter", k), outs(), 32'h1405);
      alarm_do = 1'b0;
      for (int t = 0; t < 4; t++) begin
        cyc(); tick();
      end
      cyc(); tick();
      chk($sformatf("snzk%0d_retrig", k), 32'({ringing, snooze_retrig}), 3);
      alarm_do = 1'b1;
      cyc();
    end
    press_snz();
    chk("snz4_dismiss", outs(), 32'h400);
    for (int t = 0; t < 6; t++) begin
      cyc(); tick();
    end
    chk("snz4_stays_idle", outs(), 32'd0);
    alarm_do = 1'b0;
    cyc();
    alarm_do = 1'b1;
    cyc();
    press_snz();
    chk("new_event_resets_cnt", 32'(snooze_left), 5);
    alarm_do = 1'b0;
    cyc();
    press_dis();
    chk("snz_dismiss_noclear", outs(), 32'd0);

    // unattended timeout on the 60th tick
    alarm_do = 1'b1;
    cyc();
    for (int t = 1; t <= 59; t++) begin
      tick(); cyc();
    end
    chk("timeout_59", 32'({ringing, alarm_clear}), 2);
    tick();
    chk("timeout_60", outs(), 32'h400);
    alarm_do = 1'b0;
    cyc();
    chk("timeout_end", outs(), 32'd0);

    // same-cycle priority: dismiss over snooze, dismiss over snooze expiry
    alarm_do = 1'b1;
    cyc();
    dismiss = 1'b1; snooze = 1'b1;
    cyc();
    dismiss = 1'b0; snooze = 1'b0;
    chk("prio_dis_snz", outs(), 32'h400);
    alarm_do = 1'b0;
    cyc();
    alarm_do = 1'b1;
    cyc();
    press_snz();
    alarm_do = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cyc(); tick();
    end
    chk("prio_left1", 32'(snooze_left), 1);
    dismiss = 1'b1; sec_tick = 1'b1;
    cyc();
    dismiss = 1'b0; sec_tick = 1'b0;
    chk("prio_dis_expiry", outs(), 32'd0);

`ifdef ESCALATE_EN
    alarm_do = 1'b1;
    cyc();
    for (int t = 0; t < 10; t++) begin
      repeat (15) cyc();
      tick();
    end
    toggles = 0;
    prev_b = buzzer;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (buzzer !== prev_b) toggles++;
      prev_b = buzzer;
    end
    chk("esc_toggles", 32'(toggles), 8);
    chk("esc_ringing", 32'(ringing), 1);
`else
    toggles = 0;
    prev_b = 1'b0;
    if (toggles != 0 || prev_b) $display("unexpected local state");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
